// File: rtl/mem_port_arbiter.sv
// Shares one single-ported unified memory between fetch (IF) and load/store (MEM); 2 cycles min req->valid.
// Requesters hold req until their *_valid pulse; memory backpressures via mem_ready while mem_* stay stable.
module mem_port_arbiter #(
  parameter int XLEN         = 32,
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                flush_f,
  output logic                i_valid,
  output logic [XLEN-1:0]     i_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [XLEN/8-1:0]   d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [XLEN-1:0]     d_wdata,
  output logic                d_valid,
  output logic [XLEN-1:0]     d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [XLEN/8-1:0]   mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic                mem_ready,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                stall_f,
  output logic                stall_m
);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] starve_cnt;
  logic             flushed;
  logic             i_act, d_act, i_contend, grant_d, grant_i;

  // A requester whose completion pulse is out this cycle is still holding req; ignore it.
  assign i_act     = i_req & ~i_valid;
  assign d_act     = d_req & ~d_valid;
  assign i_contend = i_act & ~flush_f;
  assign grant_d   = (state == IDLE) & d_act & ~(i_contend & (starve_cnt == LIMIT));
  assign grant_i   = (state == IDLE) & ~grant_d & i_contend;

  assign stall_f = i_req & ~i_valid;
  assign stall_m = d_req & ~d_valid;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant_d)      state_nxt = BUSY_D;
        else if (grant_i) state_nxt = BUSY_I;
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
      flushed    <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      i_valid    <= 1'b0;
      d_valid    <= 1'b0;
      i_rdata    <= '0;
      d_rdata    <= '0;
    end else begin
      state   <= state_nxt;
      i_valid <= 1'b0;
      d_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_be    <= d_be;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            if (i_contend && (starve_cnt != LIMIT)) starve_cnt <= starve_cnt + CNT_W'(1);
          end else if (grant_i) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_be     <= '1;
            mem_addr   <= i_addr;
            mem_wdata  <= '0;
            starve_cnt <= '0;
            flushed    <= 1'b0;
          end
        end
        BUSY_I: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            flushed <= 1'b0;
            // A redirect seen at any point during the access discards its result.
            if (!(flushed || flush_f)) begin
              i_valid <= 1'b1;
              i_rdata <= mem_rdata;
            end
          end else if (flush_f) begin
            flushed <= 1'b1;
          end
        end
        BUSY_D: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            d_valid <= 1'b1;
            if (!mem_we) d_rdata <= mem_rdata;
          end
        end
        default: mem_req <= 1'b0;
      endcase
    end
  end

endmodule
